// File: rtl/key_cond_pkg.sv
// key_cond_pkg: shared definitions for the key conditioner.
//   - key_state_e : per-channel debounce/hold FSM states
//   - DEF_*       : default timing for the 50 MHz board clock
//   - cnt_width() : width of a counter that must hold values 0..max_val
package key_cond_pkg;

  typedef enum logic [2:0] {
    RELEASED    = 3'd0,
    PRESS_DEB   = 3'd1,
    PRESSED     = 3'd2,
    REPEATING   = 3'd3,
    RELEASE_DEB = 3'd4
  } key_state_e;

  localparam int unsigned DEF_N_KEYS   = 4;
  localparam int unsigned DEF_DEB_CYC  = 1000000;   // 20 ms
  localparam int unsigned DEF_LONG_CYC = 25000000;  // 500 ms
  localparam int unsigned DEF_REP_CYC  = 5000000;   // 100 ms

  // One spare bit above $clog2 so the terminal value itself always fits.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// key_conditioner_if: bundle of raw key inputs and conditioned key outputs.
//   master : key source / consumer side (drives key_in, observes outputs)
//   slave  : the conditioner (reads key_in, drives the conditioned outputs)
//   key_in      raw asynchronous key inputs
//   key_level   debounced pressed level (1 = pressed)
//   key_press   one-cycle pulse on accepted press
//   key_release one-cycle pulse on accepted release
//   key_repeat  one-cycle auto-repeat pulse
//   key_long    high while a press has lasted at least LONG_CYC
interface key_conditioner_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] key_in;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_repeat;
  logic [N_KEYS-1:0] key_long;

  modport master (
    output key_in,
    input  key_level, key_press, key_release, key_repeat, key_long
  );

  modport slave (
    input  key_in,
    output key_level, key_press, key_release, key_repeat, key_long
  );
endinterface

// File: rtl/key_cond_ch.sv
// key_cond_ch: one key channel -- 2-FF synchronizer, polarity normalisation,
// debounce/hold FSM and its counters. All outputs are registered.
// Optional feature macro: KEY_CONDITIONER_AUTOREPEAT_EN (auto-repeat and
// long-press; when undefined the REPEATING path and hold/rep counters are
// not built and key_repeat/key_long are tied low).
// Ports:
//   clk, rst_N   board clock, asynchronous active-low reset
//   key_raw      raw asynchronous key input
//   key_level    debounced pressed level
//   key_press    one-cycle press pulse
//   key_release  one-cycle release pulse
//   key_repeat   one-cycle auto-repeat pulse
//   key_long     long-press flag
module key_cond_ch
  import key_cond_pkg::*;
#(
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter int unsigned DEB_CYC    = DEF_DEB_CYC,
  parameter int unsigned LONG_CYC   = DEF_LONG_CYC,
  parameter int unsigned REP_CYC    = DEF_REP_CYC
) (
  input  logic clk,
  input  logic rst_N,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_repeat,
  output logic key_long
);

  localparam int unsigned MAX_DL  = (DEB_CYC > LONG_CYC) ? DEB_CYC : LONG_CYC;
  localparam int unsigned MAX_CYC = (MAX_DL > REP_CYC) ? MAX_DL : REP_CYC;
  localparam int unsigned CW      = cnt_width(MAX_CYC);

  // Raw level of a released key; synchronizer flops reset to this.
  localparam logic          RAW_IDLE = ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [CW-1:0] DEB_LIM  = CW'(DEB_CYC);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic sync1_reg, sync2_reg;
  logic key_p;

  key_state_e    state_reg, state_next;
  logic [CW-1:0] deb_cnt_reg, deb_cnt_next;
  logic          deb_done;

  logic level_reg, level_next;
  logic press_reg, press_next;
  logic release_reg, release_next;

  assign key_p    = ACTIVE_LOW ? ~sync2_reg : sync2_reg;
  assign deb_done = (deb_cnt_reg >= DEB_LIM);

`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
  localparam logic [CW-1:0] LONG_LIM = CW'(LONG_CYC);
  localparam logic [CW-1:0] REP_LIM  = CW'(REP_CYC);

  logic [CW-1:0] hold_cnt_reg, hold_cnt_next, hold_inc;
  logic [CW-1:0] rep_cnt_reg, rep_cnt_next, rep_inc;
  logic          hold_hit, rep_hit;
  logic          repeat_reg, repeat_next;
  logic          long_reg, long_next;

  // hold_cnt never exceeds LONG_LIM, so the increment cannot overflow.
  assign hold_inc = hold_cnt_reg + CNT_ONE;
  assign rep_inc  = rep_cnt_reg + CNT_ONE;
  assign hold_hit = (hold_cnt_reg < LONG_LIM) && (hold_inc == LONG_LIM);
  assign rep_hit  = (rep_inc >= REP_LIM);
`endif

  // State, counter, synchronizer and output registers.
  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      sync1_reg    <= RAW_IDLE;
      sync2_reg    <= RAW_IDLE;
      state_reg    <= RELEASED;
      deb_cnt_reg  <= '0;
      level_reg    <= 1'b0;
      press_reg    <= 1'b0;
      release_reg  <= 1'b0;
`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
      hold_cnt_reg <= '0;
      rep_cnt_reg  <= '0;
      repeat_reg   <= 1'b0;
      long_reg     <= 1'b0;
`endif
    end else begin
      sync1_reg    <= key_raw;
      sync2_reg    <= sync1_reg;
      state_reg    <= state_next;
      deb_cnt_reg  <= deb_cnt_next;
      level_reg    <= level_next;
      press_reg    <= press_next;
      release_reg  <= release_next;
`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
      hold_cnt_reg <= hold_cnt_next;
      rep_cnt_reg  <= rep_cnt_next;
      repeat_reg   <= repeat_next;
      long_reg     <= long_next;
`endif
    end
  end

  // Next-state and counter logic. Any cycle spent leaving or re-entering
  // a debounce state does not advance hold/rep, so a bounce freezes them.
  always_comb begin
    state_next    = state_reg;
    deb_cnt_next  = deb_cnt_reg;
`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
    hold_cnt_next = hold_cnt_reg;
    rep_cnt_next  = rep_cnt_reg;
`endif
    unique case (state_reg)
      RELEASED: begin
        if (key_p) begin
          state_next   = PRESS_DEB;
          deb_cnt_next = CNT_ONE;
        end
      end
      PRESS_DEB: begin
        if (!key_p) begin
          state_next = RELEASED;
        end else if (deb_done) begin
          state_next    = PRESSED;
`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
          hold_cnt_next = '0;
`endif
        end else begin
          deb_cnt_next = deb_cnt_reg + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!key_p) begin
          state_next   = RELEASE_DEB;
          deb_cnt_next = CNT_ONE;
        end
`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
        else if (hold_cnt_reg < LONG_LIM) begin
          hold_cnt_next = hold_inc;
          if (hold_hit) begin
            state_next   = REPEATING;
            rep_cnt_next = '0;
          end
        end
`endif
      end
`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
      REPEATING: begin
        if (!key_p) begin
          state_next   = RELEASE_DEB;
          deb_cnt_next = CNT_ONE;
        end else if (rep_hit) begin
          rep_cnt_next = '0;
        end else begin
          rep_cnt_next = rep_inc;
        end
      end
`endif
      RELEASE_DEB: begin
        if (key_p) begin
`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
          state_next = long_reg ? REPEATING : PRESSED;
`else
          state_next = PRESSED;
`endif
        end else if (deb_done) begin
          state_next = RELEASED;
        end else begin
          deb_cnt_next = deb_cnt_reg + CNT_ONE;
        end
      end
      default: state_next = RELEASED;
    endcase
  end

  // Output decode: values the output registers take at the next edge.
  always_comb begin
    level_next   = level_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
    repeat_next  = 1'b0;
    long_next    = long_reg;
`endif
    unique case (state_reg)
      PRESS_DEB: begin
        if (key_p && deb_done) begin
          level_next = 1'b1;
          press_next = 1'b1;
        end
      end
`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
      PRESSED: begin
        if (key_p && hold_hit) begin
          repeat_next = 1'b1;
          long_next   = 1'b1;
        end
      end
      REPEATING: begin
        if (key_p && rep_hit) begin
          repeat_next = 1'b1;
        end
      end
`endif
      RELEASE_DEB: begin
        if (!key_p && deb_done) begin
          level_next   = 1'b0;
          release_next = 1'b1;
`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
          long_next    = 1'b0;
`endif
        end
      end
      default: ;
    endcase
  end

  assign key_level   = level_reg;
  assign key_press   = press_reg;
  assign key_release = release_reg;
`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
  assign key_repeat  = repeat_reg;
  assign key_long    = long_reg;
`else
  assign key_repeat  = 1'b0;
  assign key_long    = 1'b0;
`endif

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: conditions N_KEYS raw push-buttons/switches into debounced
// levels, press/release pulses and (optionally) auto-repeat and long-press.
// Optional feature macro: KEY_CONDITIONER_AUTOREPEAT_EN.
// Ports:
//   clk    board clock
//   rst_N  asynchronous active-low reset
//   kif    key_conditioner_if.slave: key_in in, conditioned outputs out
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int unsigned N_KEYS     = DEF_N_KEYS,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter int unsigned DEB_CYC    = DEF_DEB_CYC,
  parameter int unsigned LONG_CYC   = DEF_LONG_CYC,
  parameter int unsigned REP_CYC    = DEF_REP_CYC
) (
  input  logic             clk,
  input  logic             rst_N,
  key_conditioner_if.slave kif
);

  logic [N_KEYS-1:0] level_vec;
  logic [N_KEYS-1:0] press_vec;
  logic [N_KEYS-1:0] release_vec;
  logic [N_KEYS-1:0] repeat_vec;
  logic [N_KEYS-1:0] long_vec;

  // Channels share nothing but clock and reset.
  generate
    for (genvar gi = 0; gi < int'(N_KEYS); gi++) begin : g_ch
      key_cond_ch #(
        .ACTIVE_LOW (ACTIVE_LOW),
        .DEB_CYC    (DEB_CYC),
        .LONG_CYC   (LONG_CYC),
        .REP_CYC    (REP_CYC)
      ) u_ch (
        .clk         (clk),
        .rst_N       (rst_N),
        .key_raw     (kif.key_in[gi]),
        .key_level   (level_vec[gi]),
        .key_press   (press_vec[gi]),
        .key_release (release_vec[gi]),
        .key_repeat  (repeat_vec[gi]),
        .key_long    (long_vec[gi])
      );
    end
  endgenerate

  assign kif.key_level   = level_vec;
  assign kif.key_press   = press_vec;
  assign kif.key_release = release_vec;
  assign kif.key_repeat  = repeat_vec;
  assign kif.key_long    = long_vec;

`ifndef SYNTHESIS
  // A zero timing parameter would make a counter terminal value unreachable.
  always @(posedge clk) begin
    assert (DEB_CYC >= 1 && LONG_CYC >= 1 && REP_CYC >= 1)
      else $error("key_conditioner: DEB_CYC, LONG_CYC and REP_CYC must be >= 1");
  end
`endif

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Upstream front-end for the clock's control logic: conditions raw, bouncy push-buttons and switches into clean levels and single-cycle pulses.
- Per key it provides a debounced level, press and release pulses, and a long-press flag.
- When enabled, it also emits auto-repeat pulses so that holding up/down scrolls a value.
- Runs in the board clock domain; one identical channel per key.

Parameters:
- N_KEYS, 4, number of key channels.
- ACTIVE_LOW, 1, 1 = raw input pressed when 0; 0 = pressed when 1.
- DEB_CYC, 1000000, consecutive stable clk cycles required to accept a change (20 ms at 50 MHz).
- LONG_CYC, 25000000, clk cycles from press pulse to first repeat pulse / long flag.
- REP_CYC, 5000000, clk cycles between subsequent repeat pulses.

Ports:
- clk  in  1  board clock.
- rst_N  in  1  asynchronous active-low reset.
- key_in  in  N_KEYS  raw asynchronous key inputs.
- key_level  out  N_KEYS  debounced pressed level, 1 = pressed.
- key_press  out  N_KEYS  one-cycle pulse on accepted press.
- key_release  out  N_KEYS  one-cycle pulse on accepted release.
- key_repeat  out  N_KEYS  one-cycle auto-repeat pulse.
- key_long  out  N_KEYS  1 while a press has lasted at least LONG_CYC.

Behaviour:
- Reset: asynchronous and active-low, as already decided for this block (single clock clk, reset rst_N).
  - On reset, all outputs are 0 and every FSM is in RELEASED.
  - Synchronizer flops reset to the released polarity.
  - Reset mid-press: no release pulse is emitted; after deassertion a still-held key must be re-debounced and yields a fresh press pulse.
- Input path: 2-FF synchronizer per bit, then polarity normalisation to p = pressed.
- Edge t is the first clk edge that samples a new raw value. The accepted change appears on edge t+2+DEB_CYC, assuming a stable input.
- All outputs are registered.
- Per-channel FSM:
  - RELEASED: if p=1, go to PRESS_DEB and set deb_cnt=1.
  - PRESS_DEB:
    - p=0 returns to RELEASED with no pulse.
    - p=1 increments deb_cnt.
    - When deb_cnt reaches DEB_CYC: go to PRESSED, set key_level=1, pulse key_press, clear hold_cnt.
  - PRESSED:
    - hold_cnt increments each cycle.
    - At hold_cnt=LONG_CYC: set key_long=1, pulse key_repeat, go to REPEATING, clear rep_cnt.
    - p=0 goes to RELEASE_DEB.
  - REPEATING:
    - rep_cnt increments.
    - At REP_CYC: pulse key_repeat and clear rep_cnt.
    - p=0 goes to RELEASE_DEB.
  - RELEASE_DEB:
    - hold_cnt and rep_cnt are frozen and no repeat pulses are emitted.
    - p=1 (bounce) returns to REPEATING if key_long=1, else PRESSED; counters resume from their frozen values.
    - After DEB_CYC consecutive p=0: go to RELEASED, set key_level=0 and key_long=0, pulse key_release.
- key_press and key_repeat never assert in the same cycle. The first repeat comes exactly LONG_CYC cycles after key_press.
- Glitches shorter than DEB_CYC cycles produce no output change.
- Channels are fully independent. Simultaneous presses on several keys give simultaneous pulses.
- Counter widths are $clog2(max parameter)+1. Counters saturate and never wrap; hold_cnt stops at LONG_CYC.
- DEB_CYC, LONG_CYC and REP_CYC must each be >= 1. Illegal values are flagged by a simulation-only assertion.

Optional Feature:
- Macro: KEY_CONDITIONER_AUTOREPEAT_EN.
- Defined: full behaviour above, including PRESSED→REPEATING, key_repeat and key_long.
- Undefined:
  - The REPEATING state, hold_cnt and rep_cnt are not built.
  - key_repeat and key_long are tied to 0.
  - PRESSED only leaves on p=0, and a bounce in RELEASE_DEB always returns to PRESSED.

Decomposition:
- Shared package key_cond_pkg holds:
  - the FSM state enum (RELEASED, PRESS_DEB, PRESSED, REPEATING, RELEASE_DEB);
  - default timing constants for the 50 MHz board;
  - a function computing counter width.
- Sub-module key_cond_ch: one channel containing synchronizer, FSM and counters.
- key_conditioner instantiates N_KEYS key_cond_ch in a generate loop and concatenates their outputs.

Test Plan:
Bench uses DEB_CYC=4, LONG_CYC=20, REP_CYC=5, ACTIVE_LOW=1, feature enabled unless noted.
1. Reset with key_in=4'b1111, then release reset → all outputs 0 for 50 cycles; assert rst_N low mid-hold → outputs 0 immediately (asynchronous).
2. key_in[0]=0 first sampled at edge t and held → key_press[0] high for exactly one cycle at edge t+6, key_level[0]=1 from t+6; other channels stay 0.
3. key_in[1] low for 3 cycles then high (bounce) → no key_press[1] and key_level[1] stays 0; follow with a stable press → one press pulse only.
4. Hold key 2, with press pulse at cycle P → key_repeat[2] pulses at P+20, P+25 and P+30, key_long[2] rises at P+20; release → key_release[2] 6 cycles after the first release edge and key_long[2] cleared in the same cycle.
5. During hold, release bounce of 2 cycles at P+22 → no release pulse; repeat timing resumes from the frozen count with no pulse lost or duplicated.
6. Feature macro undefined, hold key 3 for 100 cycles → key_repeat and key_long stay 0; press and release pulses as in test 2.
